seg_scan_display: RTL and testbench
===================================

Name: seg_scan_display

Overview:
- Parametrised multiplexed seven-segment display driver; next generation of the fixed 4-digit an/bcd output path of the pipelined CPU top level.
- Takes a packed hex value plus per-digit decimal points from the CPU's peripheral logic.
- Latches the value into a shadow register and commits it to the displayed copy only at scan-frame boundaries, so the display never tears.
- Cycles through NUM_DIGITS common-anode digits at a programmable refresh rate.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..16.
- CLK_DIV, 100000, clock cycles each digit stays on; legal minimum 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- value  in  4*NUM_DIGITS  packed hex nibbles; nibble i (bits 4i+3:4i) drives digit i
- dp_in  in  NUM_DIGITS  decimal-point request per digit, active high
- load  in  1  one-cycle strobe; captures value/dp_in into the shadow register
- blank  in  1  forces display dark while high
- an  out  NUM_DIGITS  digit enables, active low, one-hot-low while scanning
- bcd  out  8  segments, active low: bit0=a .. bit6=g, bit7=dp
- frame_done  out  1  one-cycle pulse when the digit index wraps to 0
- pending  out  1  high while shadow holds data not yet committed

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All state changes on the rising edge of clk.
- Reset values: an all ones, bcd 8'hFF, frame_done 0, pending 0. Internally, prescaler 0, digit index 0, and shadow and active registers all zero.
- Reset mid-frame returns everything to these values. Any pending load is discarded.
- Prescaler counts 0..CLK_DIV-1. On reaching CLK_DIV-1 it wraps to 0 and the digit index advances.
- Digit index counts 0..NUM_DIGITS-1, then wraps to 0.
- The wrap from NUM_DIGITS-1 to 0 is a frame boundary. On that edge frame_done is 1 for exactly one cycle.
- Also at a frame boundary, if pending=1: active <= shadow and pending <= 0.
- When NUM_DIGITS=1, every prescaler wrap is a frame boundary.
- load=1: shadow <= {value, dp_in} and pending <= 1 on the same edge. Loads while pending overwrite the shadow; last one wins.
- load coincident with a frame boundary: the commit uses the shadow contents from before that edge. The new data is captured into shadow, pending stays 1, and the new data commits at the next boundary.
- If no earlier load is pending, the coincident load is simply not shown until the next frame.
- Outputs an and bcd are registered: one cycle latency from the digit index and active data.
- Digit k active drives an[k]=0 and all other bits 1.
- Segment decode, active low with dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- dp asserted on a digit clears bcd[7].
- blank=1: next cycle an=all ones and bcd=8'hFF. Scanning, prescaler, load capture and commits continue unaffected.
- No handshake back-pressure: load is always accepted.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits above the highest-index nonzero nibble of the active value show bcd[6:0]=7'h7F. Their dp still follows dp_in.
  - Digit 0 is never blanked, so all-zero shows "0" on digit 0 only.
  - an still scans every digit.
- Undefined: every digit decodes its nibble normally, including leading zeros.

Test Plan:
- Use NUM_DIGITS=4 and CLK_DIV=4 for all scenarios.
- Reset then release: an=1111 and bcd=FF during reset. Then an=1110, bcd=C0 for 4 cycles, then 1101, 1011, 0111. frame_done pulses once per 16 cycles.
- load value=16'h12AF, dp_in=4'b0100 mid-frame: pending=1 until the next wrap, with the display unchanged. Then digit0=8E, digit1=88, digit2=24 (A4 with dp cleared), digit3=F9. pending drops with the frame_done pulse.
- Two loads in one frame (16'h1111, then 16'h2222): only 2222 is displayed after the wrap; 1111 never appears.
- load 16'h5555 on the exact frame-boundary cycle, prior shadow committed already: the display keeps old data for one full frame, then shows 92 on all digits. pending is 1 throughout that frame.
- blank held for 10 cycles: an=1111 and bcd=FF one cycle after assertion. The digit index continues, so after release the scan resumes at the digit index reached meanwhile.
- With SEG_LEADING_ZERO_BLANK_EN, load 16'h0030: digits 3 and 2 show FF, digit1 shows B0, digit0 shows C0. Without the macro, digits 3 and 2 show C0.

Source files
------------

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment driver with frame-synchronous shadow commit.
// Optional SEG_LEADING_ZERO_BLANK_EN darkens digits above the top nonzero nibble.
module seg_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              bcd,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(CLK_DIV);

    logic [PW-1:0]                 presc_q, presc_d;
    logic [DW-1:0]                 digit_q, digit_d;
    logic [NUM_DIGITS-1:0][3:0]    shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0][3:0]    active_val_q, active_val_d;
    logic [NUM_DIGITS-1:0]         shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]         active_dp_q, active_dp_d;
    logic                          pending_q, pending_d;
    logic                          frame_q, frame_d;
    logic [NUM_DIGITS-1:0]         an_q, an_d;
    logic [7:0]                    bcd_q, bcd_d;

    logic                          presc_wrap;
    logic                          digit_last;
    logic                          frame_edge;
    logic [3:0]                    nib;
    logic [6:0]                    seg;
    logic                          seg_dark;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  seen_nz;

    // Digit 0 always stays lit so an all-zero value still reads "0".
    always_comb begin
        lead_zero = '0;
        seen_nz   = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            seen_nz      = seen_nz | (active_val_q[i] != 4'h0);
            lead_zero[i] = ~seen_nz;
        end
        seg_dark = lead_zero[digit_q];
    end
`else
    assign seg_dark = 1'b0;
`endif

    assign nib = active_val_q[digit_q];
    assign seg = hex7(nib);

    always_comb begin
        presc_wrap   = (presc_q == PW'(CLK_DIV - 1));
        digit_last   = (digit_q == DW'(NUM_DIGITS - 1));
        frame_edge   = presc_wrap && digit_last;

        presc_d      = presc_wrap ? '0 : presc_q + 1'b1;
        digit_d      = digit_q;
        if (presc_wrap) begin
            digit_d = digit_last ? '0 : digit_q + 1'b1;
        end

        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        active_val_d = active_val_q;
        active_dp_d  = active_dp_q;
        pending_d    = pending_q;

        // Commit sees the pre-edge shadow; a coincident load waits a frame.
        if (frame_edge && pending_q) begin
            active_val_d = shadow_val_q;
            active_dp_d  = shadow_dp_q;
            pending_d    = 1'b0;
        end
        if (load) begin
            shadow_val_d = value;
            shadow_dp_d  = dp_in;
            pending_d    = 1'b1;
        end

        frame_d = frame_edge;

        if (blank) begin
            an_d  = '1;
            bcd_d = 8'hFF;
        end else begin
            an_d  = ~(NUM_DIGITS'(1) << digit_q);
            bcd_d = {~active_dp_q[digit_q], seg_dark ? 7'h7F : seg};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q      <= '0;
            digit_q      <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            active_val_q <= '0;
            active_dp_q  <= '0;
            pending_q    <= 1'b0;
            frame_q      <= 1'b0;
            an_q         <= '1;
            bcd_q        <= 8'hFF;
        end else begin
            presc_q      <= presc_d;
            digit_q      <= digit_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            active_val_q <= active_val_d;
            active_dp_q  <= active_dp_d;
            pending_q    <= pending_d;
            frame_q      <= frame_d;
            an_q         <= an_d;
            bcd_q        <= bcd_d;
        end
    end

    assign an         = an_q;
    assign bcd        = bcd_q;
    assign frame_done = frame_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with NUM_DIGITS=4, CLK_DIV=4.
// Leading-zero expectations follow SEG_LEADING_ZERO_BLANK_EN when defined.
module tb_seg_scan_display;

    localparam int ND = 4;
    localparam int CD = 4;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ = 8'hFF;
`else
    localparam logic [7:0] LZ = 8'hC0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   value;
    logic [3:0]    dp_in;
    logic          load;
    logic          blank;
    logic [3:0]    an;
    logic [7:0]    bcd;
    logic          frame_done;
    logic          pending;

    int n_chk = 0;
    int n_err = 0;

    seg_scan_display #(
        .NUM_DIGITS(ND),
        .CLK_DIV   (CD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .dp_in     (dp_in),
        .load      (load),
        .blank     (blank),
        .an        (an),
        .bcd       (bcd),
        .frame_done(frame_done),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one 16-cycle frame starting right after a boundary edge.
    task automatic scan_frame(input string nm, input logic [31:0] eb,
                              input logic [15:0] pm,
                              input int la, input logic [15:0] va,
                              input logic [3:0] da,
                              input int lb, input logic [15:0] vb,
                              input logic [3:0] db);
        logic [3:0] ea;
        logic [7:0] ed;
        for (int j = 0; j < 16; j++) begin
            load = 1'b0;
            if (j == la) begin
                load  = 1'b1;
                value = va;
                dp_in = da;
            end
            if (j == lb) begin
                load  = 1'b1;
                value = vb;
                dp_in = db;
            end
            step();
            load = 1'b0;
            ea = ~(4'b0001 << (j / 4));
            ed = eb[8*(j/4) +: 8];
            chk($sformatf("%s an[%0d]", nm, j), 32'(an), 32'(ea));
            chk($sformatf("%s bcd[%0d]", nm, j), 32'(bcd), 32'(ed));
            chk($sformatf("%s fd[%0d]", nm, j), 32'(frame_done),
                32'(j == 15));
            chk($sformatf("%s pend[%0d]", nm, j), 32'(pending),
                32'(pm[j]));
        end
    endtask

    initial begin
        reset = 1'b1;
        value = '0;
        dp_in = '0;
        load  = 1'b0;
        blank = 1'b0;
        repeat (3) step();
        chk("rst an", 32'(an), 32'hF);
        chk("rst bcd", 32'(bcd), 32'hFF);
        chk("rst fd", 32'(frame_done), 32'h0);
        chk("rst pend", 32'(pending), 32'h0);
        reset = 1'b0;

        scan_frame("f1", {LZ, LZ, LZ, 8'hC0}, 16'h0000,
                   -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        scan_frame("f2", {LZ, LZ, LZ, 8'hC0}, 16'h7FFC,
                   2, 16'h12AF, 4'b0100, -1, 16'h0, 4'h0);
        scan_frame("f3", {8'hF9, 8'h24, 8'h88, 8'h8E}, 16'h7FF8,
                   3, 16'h1111, 4'h0, 9, 16'h2222, 4'h0);
        scan_frame("f4", {4{8'hA4}}, 16'h8000,
                   15, 16'h5555, 4'h0, -1, 16'h0, 4'h0);
        scan_frame("f5", {4{8'hA4}}, 16'h7FFF,
                   -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        scan_frame("f6", {4{8'h92}}, 16'h0000,
                   -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        for (int j = 0; j < 16; j++) begin
            logic [3:0] ea;
            blank = (j < 10);
            step();
            ea = (j < 10) ? 4'hF : ~(4'b0001 << (j / 4));
            chk($sformatf("blk an[%0d]", j), 32'(an), 32'(ea));
            chk($sformatf("blk bcd[%0d]", j), 32'(bcd),
                (j < 10) ? 32'hFF : 32'h92);
            chk($sformatf("blk fd[%0d]", j), 32'(frame_done),
                32'(j == 15));
        end
        blank = 1'b0;

        scan_frame("f8", {4{8'h92}}, 16'h7FFF,
                   0, 16'h0030, 4'h0, -1, 16'h0, 4'h0);
        scan_frame("f9", {LZ, LZ, 8'hB0, 8'hC0}, 16'h0000,
                   -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        for (int j = 0; j < 5; j++) begin
            load  = (j == 1);
            value = 16'h8888;
            step();
            load = 1'b0;
        end
        chk("mid pend", 32'(pending), 32'h1);
        reset = 1'b1;
        step();
        step();
        chk("mrst an", 32'(an), 32'hF);
        chk("mrst bcd", 32'(bcd), 32'hFF);
        chk("mrst fd", 32'(frame_done), 32'h0);
        chk("mrst pend", 32'(pending), 32'h0);
        reset = 1'b0;

        scan_frame("r1", {LZ, LZ, LZ, 8'hC0}, 16'h0000,
                   -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        scan_frame("r2", {LZ, LZ, LZ, 8'hC0}, 16'h0000,
                   -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
